// File: rtl/datapath_m.sv
// rtl/datapath_m.sv - VeriRISC datapath: program counter, instruction register, accumulator and ALU.
module datapath_m #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              fetch,
    input  logic              load_ac,
    input  logic              load_ir,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              halt,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [2:0]        opcode,
    output logic              zero,
    output logic [AWIDTH-1:0] pc,
    output logic              halted
);

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] ir_q, ir_d;
    logic [DWIDTH-1:0] ac_q, ac_d;
    logic              halted_q, halted_d;
    logic [DWIDTH-1:0] alu_out;
    opcode_e           op;

    assign op = opcode_e'(ir_q[DWIDTH-1:DWIDTH-3]);

    always_comb begin
        alu_out = ac_q;
        unique case (op)
            OP_ADD:  alu_out = ac_q + mem_rdata;
            OP_AND:  alu_out = ac_q & mem_rdata;
            OP_XOR:  alu_out = ac_q ^ mem_rdata;
            OP_LDA:  alu_out = mem_rdata;
            default: alu_out = ac_q;
        endcase
    end

    // Once halted, every architectural register freezes until reset.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        ac_d     = ac_q;
        halted_d = halted_q | halt;
        if (!halted_q) begin
            if (load_pc) begin
                pc_d = ir_q[AWIDTH-1:0];
            end else if (inc_pc) begin
                pc_d = pc_q + AWIDTH'(1);
            end
            if (load_ir) begin
                ir_d = mem_rdata;
            end
            if (load_ac) begin
                ac_d = alu_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            halted_q <= halted_d;
        end
    end

    assign mem_addr  = fetch ? pc_q : ir_q[AWIDTH-1:0];
    assign mem_wdata = ac_q;
    assign opcode    = ir_q[DWIDTH-1:DWIDTH-3];
    assign zero      = (ac_q == '0);
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_datapath_m.sv
// tb/tb_datapath_m.sv - self-checking bench for datapath_m against a behavioural reference model.
module tb_datapath_m;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       fetch = 1'b0, load_ac = 1'b0, load_ir = 1'b0;
    logic       inc_pc = 1'b0, load_pc = 1'b0, halt = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] pc;
    logic       halted;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] m_pc;
    logic [7:0] m_ir;
    logic [7:0] m_ac;
    logic       m_halted;

    datapath_m #(.DWIDTH(8), .AWIDTH(5)) dut (
        .clk(clk), .rst_(rst_), .fetch(fetch), .load_ac(load_ac), .load_ir(load_ir),
        .inc_pc(inc_pc), .load_pc(load_pc), .halt(halt), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .opcode(opcode), .zero(zero),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd2:    return 8'((int'(a) + int'(b)) % 256);
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return b;
            default: return a;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".pc"},     32'(pc),        32'(m_pc));
        check({tag, ".opcode"}, 32'(opcode),    32'(m_ir[7:5]));
        check({tag, ".zero"},   32'(zero),      32'(m_ac == 8'd0));
        check({tag, ".addr"},   32'(mem_addr),  32'(fetch ? m_pc : m_ir[4:0]));
        check({tag, ".wdata"},  32'(mem_wdata), 32'(m_ac));
        check({tag, ".halted"}, 32'(halted),    32'(m_halted));
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_ac = 0; m_halted = 0;
    endtask

    // Advance one clock; the model computes next state from pre-edge values.
    task automatic step();
        logic [4:0] npc;
        logic [7:0] nir, nac;
        logic       nh;
        npc = m_pc; nir = m_ir; nac = m_ac; nh = m_halted;
        if (rst_) begin
            if (!m_halted) begin
                if (load_pc)     npc = m_ir[4:0];
                else if (inc_pc) npc = 5'((int'(m_pc) + 1) % 32);
                if (load_ac)     nac = alu_ref(m_ir[7:5], m_ac, mem_rdata);
                if (load_ir)     nir = mem_rdata;
            end
            if (halt) nh = 1'b1;
        end
        @(posedge clk);
        #1;
        m_pc = npc; m_ir = nir; m_ac = nac; m_halted = nh;
    endtask

    task automatic strobes(input logic f, input logic lac, input logic lir,
                           input logic ipc, input logic lpc, input logic h, input logic [7:0] rd);
        fetch = f; load_ac = lac; load_ir = lir; inc_pc = ipc; load_pc = lpc; halt = h; mem_rdata = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ops [3]  = '{8'h40, 8'h60, 8'h80};
        logic [7:0] exps [3] = '{8'h10, 8'h20, 8'hD0};
        logic [4:0] hold_pc;
        logic [7:0] hold_ac;
        logic [2:0] hold_op;

        // Reset with every strobe high
        strobes(1, 1, 1, 1, 1, 1, 8'hFF);
        rst_ = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        check("reset.zero_const", 32'(zero), 32'd1);
        step();
        check_all("reset_hold");
        check("reset_hold.pc", 32'(pc), 32'd0);
        rst_ = 1'b1;

        // Fetch an LDA, then execute it with data 0
        strobes(1, 0, 1, 0, 0, 0, 8'hA5);
        step();
        check("fetch.opcode", 32'(opcode), 32'd5);
        check("fetch.addr_pc", 32'(mem_addr), 32'd0);
        fetch = 1'b0;
        #1;
        check("exec.addr_operand", 32'(mem_addr), 32'h05);
        strobes(0, 1, 0, 0, 0, 0, 8'h00);
        step();
        check("lda0.ac", 32'(mem_wdata), 32'h00);
        check("lda0.zero", 32'(zero), 32'd1);

        // ADD/AND/XOR with ac=F0, operand 20
        for (int i = 0; i < 3; i++) begin
            strobes(1, 0, 1, 0, 0, 0, 8'hA0); step();
            strobes(0, 1, 0, 0, 0, 0, 8'hF0); step();
            strobes(1, 0, 1, 0, 0, 0, ops[i]); step();
            strobes(0, 1, 0, 0, 0, 0, 8'h20); step();
            check($sformatf("alu%0d.ac", i), 32'(mem_wdata), 32'(exps[i]));
            check($sformatf("alu%0d.zero", i), 32'(zero), 32'd0);
            check_all($sformatf("alu%0d", i));
        end

        // PC wrap and load-over-increment priority
        strobes(1, 0, 1, 0, 0, 0, 8'hFF); step();
        strobes(0, 0, 0, 0, 1, 0, 8'h00); step();
        check("jmp31.pc", 32'(pc), 32'd31);
        strobes(1, 0, 0, 1, 0, 0, 8'h00); step();
        check("wrap.pc", 32'(pc), 32'd0);
        strobes(1, 0, 1, 0, 0, 0, 8'hE9); step();
        strobes(0, 0, 0, 1, 1, 0, 8'h00); step();
        check("jmp_prio.pc", 32'(pc), 32'd9);
        check_all("jmp_prio");

        // Halt freezes state until reset
        strobes(0, 0, 0, 0, 0, 1, 8'h00); step();
        check("halt.halted", 32'(halted), 32'd1);
        hold_pc = pc; hold_ac = mem_wdata; hold_op = opcode;
        for (int i = 0; i < 4; i++) begin
            strobes(1, 1, 1, 1, i[0], 0, 8'($urandom_range(1, 255)));
            step();
        end
        check("halt.pc_hold", 32'(pc), 32'(hold_pc));
        check("halt.ac_hold", 32'(mem_wdata), 32'(hold_ac));
        check("halt.op_hold", 32'(opcode), 32'(hold_op));
        check_all("halt");
        rst_ = 1'b0; model_reset(); #1;
        check("halt_rst.halted", 32'(halted), 32'd0);
        rst_ = 1'b1;

        // Randomized phase
        for (int c = 0; c < 400; c++) begin
            strobes($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 49) == 0), 8'($urandom));
            step();
            check_all($sformatf("rand%0d", c));
            if (m_halted && $urandom_range(0, 5) == 0) begin
                rst_ = 1'b0; model_reset(); #1;
                check_all($sformatf("rand_rst%0d", c));
                rst_ = 1'b1;
            end
        end

        // Reset asserted between edges while strobes are active
        if (m_halted) begin
            rst_ = 1'b0; model_reset(); #1; rst_ = 1'b1;
        end
        strobes(1, 0, 1, 0, 0, 0, 8'hA3); step();
        strobes(0, 1, 0, 1, 0, 0, 8'h5A); step();
        check("midop_pre.ac", 32'(mem_wdata), 32'h5A);
        @(negedge clk);
        strobes(1, 1, 0, 1, 0, 0, 8'h77);
        #2;
        rst_ = 1'b0;
        model_reset();
        #1;
        check_all("midop_async");
        check("midop_async.ac", 32'(mem_wdata), 32'h00);
        step();
        check_all("midop_edge");
        check("midop_edge.pc", 32'(pc), 32'd0);
        rst_ = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
